// File: rtl/if_id_queue.sv
// if_id_queue: in-order {pc, inst} buffer between fetch and decode with valid/ready flow control and flush.
// Optional macro IF_ID_BYPASS_EN lets a word reach decode in the same cycle when the queue is empty.
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     if_valid,
  input  logic [ADDR_W-1:0]        if_pc,
  input  logic [DATA_W-1:0]        if_inst,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [DATA_W-1:0]        id_inst,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             empty, full, push, pop, bypass;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];

  // The extra wrap bit tells a full queue apart from an empty one when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign count    = wr_ptr - rd_ptr;
  assign if_ready = !full;

`ifdef IF_ID_BYPASS_EN
  assign bypass = empty & if_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign id_valid = !empty | bypass;
  assign pop      = !empty & id_ready;
  // A bypassed word that decode takes immediately never needs a slot.
  assign push     = if_valid & !full & !(bypass & id_ready);

  always_comb begin
    id_pc   = '0;
    id_inst = '0;
    if (!empty) begin
      id_pc   = pc_mem[rd_idx];
      id_inst = inst_mem[rd_idx];
    end else if (bypass) begin
      id_pc   = if_pc;
      id_inst = if_inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage is deliberately left unreset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_idx]   <= if_pc;
      inst_mem[wr_idx] <= if_inst;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: scoreboard-driven bench for if_id_queue covering reset, full/backpressure, wrap, flush and latency.
// Expected words are queued as fetch words are accepted and compared as they reach the decode side.
module tb_if_id_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready = 1'b0;
  logic [2:0]  count;

  int tests_run = 0;
  int tests_failed = 0;

  entry_t exp_q[$];
  bit     do_pop, do_push;

  if_id_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0013;
  endfunction

  // Reference queue: accepts a word whenever fewer than DEPTH are held, pops when decode is ready.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      do_pop  = (exp_q.size() > 0) && id_ready;
      do_push = if_valid && (exp_q.size() < DEPTH);
`ifdef IF_ID_BYPASS_EN
      if (exp_q.size() == 0 && if_valid && id_ready) do_push = 1'b0;
`endif
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({if_pc, if_inst});
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst_of(pc);
    id_ready = rdy;
    flush    = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    tests_run++;
    if (count !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    tests_run++;
    if (id_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_id_valid got %b want 0", id_valid); end
    tests_run++;
    if (if_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_if_ready got %b want 1", if_ready); end
    tests_run++;
    if (id_pc !== 32'h0 || id_inst !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL reset_id_data got %h/%h want 0/0", id_pc, id_inst);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hA0 + 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (count !== 3'd3) begin tests_failed++; $display("[TB] FAIL async_pre_count got %0d want 3", count); end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (id_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_id_valid got %b want 0", id_valid); end
    tests_run++;
    if (count !== 3'd0) begin tests_failed++; $display("[TB] FAIL async_count got %0d want 0", count); end
    tests_run++;
    if (if_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL async_if_ready got %b want 1", if_ready); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (count !== 3'd4) begin tests_failed++; $display("[TB] FAIL fill_count got %0d want 4", count); end
    tests_run++;
    if (if_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_if_ready got %b want 0", if_ready); end
    step();
    tests_run++;
    if (count !== 3'd4) begin tests_failed++; $display("[TB] FAIL fill_overflow_count got %0d want 4", count); end
    tests_run++;
    if (id_pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL fill_head got %h want 0", id_pc); end
  endtask

  task automatic test_drain_wrap();
    logic [31:0] want [5];
    entry_t      e;
    want = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    for (int i = 0; i < 5; i++) begin
      // The full queue rejects 0x10 on the first drain cycle; it lands on the second.
      applyStimulus(i < 2, 32'h10, 1'b1, 1'b0);
      #1;
      tests_run++;
      if (id_valid !== 1'b1 || id_pc !== want[i]) begin
        tests_failed++; $display("[TB] FAIL drain_order[%0d] got %b/%h want 1/%h", i, id_valid, id_pc, want[i]);
      end
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        tests_run++;
        if (id_pc !== e.pc || id_inst !== e.inst) begin
          tests_failed++; $display("[TB] FAIL drain_sb[%0d] got %h/%h want %h/%h", i, id_pc, id_inst, e.pc, e.inst);
        end
      end
      step();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (count !== 3'd0 || id_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL drain_empty got count %0d valid %b want 0/0", count, id_valid);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h34, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b0);
    #1;
    tests_run++;
    if (id_pc !== 32'h30 || count !== 3'd2) begin
      tests_failed++; $display("[TB] FAIL b2b_pre got %h/%0d want 30/2", id_pc, count);
    end
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (count !== 3'd2) begin tests_failed++; $display("[TB] FAIL b2b_count got %0d want 2", count); end
    tests_run++;
    if (id_pc !== 32'h34) begin tests_failed++; $display("[TB] FAIL b2b_head got %h want 34", id_pc); end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    tests_run++;
    if (id_pc !== 32'h14 || id_inst !== inst_of(32'h14)) begin
      tests_failed++; $display("[TB] FAIL b2b_next got %h/%h want 14/%h", id_pc, id_inst, inst_of(32'h14));
    end
    step();
  endtask

  task automatic test_flush();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h40 + 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 32'h4C, 1'b1, 1'b1);
    #1;
    tests_run++;
    if (count !== 3'd3) begin tests_failed++; $display("[TB] FAIL flush_pre_count got %0d want 3", count); end
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (count !== 3'd0 || id_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL flush_clear got count %0d valid %b want 0/0", count, id_valid);
    end
    tests_run++;
    if (id_pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL flush_id_pc got %h want 0", id_pc); end
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 || count !== 3'd1) begin
      tests_failed++; $display("[TB] FAIL flush_next got %b/%h/%0d want 1/100/1", id_valid, id_pc, count);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_latency();
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0);
    #1;
`ifdef IF_ID_BYPASS_EN
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 32'h20) begin
      tests_failed++; $display("[TB] FAIL bypass_same_cycle got %b/%h want 1/20", id_valid, id_pc);
    end
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (count !== 3'd0 || id_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL bypass_consumed got count %0d valid %b want 0/0", count, id_valid);
    end
`else
    tests_run++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL latency_same_cycle got %b/%h want 0/0", id_valid, id_pc);
    end
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 32'h20 || count !== 3'd1) begin
      tests_failed++; $display("[TB] FAIL latency_next_cycle got %b/%h/%0d want 1/20/1", id_valid, id_pc, count);
    end
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic [31:0] pc = 32'h1000;
    logic [31:0] want_pc;
    logic        want_valid;
    entry_t      e;
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, pc, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      #1;
      want_valid = exp_q.size() > 0;
      want_pc    = 32'h0;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        want_pc = e.pc;
      end
`ifdef IF_ID_BYPASS_EN
      if (exp_q.size() == 0 && if_valid && !flush) begin
        want_valid = 1'b1;
        want_pc    = if_pc;
      end
`endif
      tests_run++;
      if (id_valid !== want_valid || id_pc !== want_pc || count !== 3'(exp_q.size()) ||
          if_ready !== (exp_q.size() < DEPTH)) begin
        tests_failed++;
        $display("[TB] FAIL random[%0d] got v%b pc %h cnt %0d rdy %b want v%b pc %h cnt %0d", i,
                 id_valid, id_pc, count, if_ready, want_valid, want_pc, exp_q.size());
      end
      if (if_valid) pc = pc + 32'h4;
      step();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_fill();
    test_drain_wrap();
    test_back_to_back();
    test_flush();
    test_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
